// File: rtl/grad_ser_pkg.sv
// -----------------------------------------------------------------------------
// grad_ser_pkg
// Shared definitions for the gradient DAC serialiser:
//   - default sizes for the frame width, chip-select count and divisor width
//   - the frame state encoding and its enum
//   - the idle (deasserted) value of the active-low chip selects
//   - a helper that sizes the bit counter so it can hold the terminal count
// -----------------------------------------------------------------------------
package grad_ser_pkg;

  localparam int FRAME_BITS_DEFAULT = 32;
  localparam int N_CH_DEFAULT       = 4;
  localparam int DIV_WIDTH_DEFAULT  = 6;

  // Fixed encodings keep the state register readable in older tool flows
  // that only understand plain vectors.
  localparam logic [1:0] ST_IDLE_ENC  = 2'b00;
  localparam logic [1:0] ST_SHIFT_ENC = 2'b01;
  localparam logic [1:0] ST_HOLD_ENC  = 2'b10;
  localparam logic [1:0] ST_GAP_ENC   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_SHIFT = ST_SHIFT_ENC,
    ST_HOLD  = ST_HOLD_ENC,
    ST_GAP   = ST_GAP_ENC
  } ser_state_e;

  // Chip selects are active low, so the idle/reset value is all ones.
  localparam logic [N_CH_DEFAULT-1:0] CS_N_RESET = {N_CH_DEFAULT{1'b1}};

  // The bit counter must reach FRAME_BITS itself (it counts rising edges),
  // so it needs enough bits for FRAME_BITS, not FRAME_BITS-1.
  function automatic int bit_cnt_width(input int frame_bits);
    return $clog2(frame_bits + 1);
  endfunction

endpackage

// File: rtl/grad_dac_serialiser_sclk_tick.sv
// -----------------------------------------------------------------------------
// grad_sclk_tick
// Loadable half-period counter for the SPI clock. When a frame is accepted the
// divisor is latched and the counter is loaded so that the first tick arrives
// exactly H = div+1 cycles after the accept edge; every later tick follows H
// cycles after the previous one for as long as the counter stays enabled.
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   load  in   frame accept strobe; latches div and restarts the count
//   div   in   SCLK half-period minus one, sampled only on load
//   en    in   frame in progress; counter parks at zero when low
//   tick  out  one-cycle strobe marking the end of each half period
// -----------------------------------------------------------------------------
module grad_sclk_tick
  import grad_ser_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 en,
  output logic                 tick
);

  // One extra bit so the counter range covers a full 64-cycle half period.
  localparam int CW = DIV_WIDTH + 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] period;
  logic [CW-1:0]        cnt;

  // Tick fires when the down-counter has run out while a frame is active.
  always_comb begin
    tick = 1'b0;
    if (en && (cnt == CNT_ZERO)) begin
      tick = 1'b1;
    end else begin
      tick = 1'b0;
    end
  end

  // Down-counter: load starts at div so that H-1 decrements plus the zero
  // cycle give H cycles; each tick reloads the latched period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period <= {DIV_WIDTH{1'b0}};
      cnt    <= CNT_ZERO;
    end else if (load) begin
      period <= div;
      cnt    <= {1'b0, div};
    end else if (!en) begin
      cnt    <= CNT_ZERO;
    end else if (cnt == CNT_ZERO) begin
      cnt    <= {1'b0, period};
    end else begin
      cnt    <= cnt - CNT_ONE;
    end
  end

endmodule

// File: rtl/grad_dac_serialiser.sv
// -----------------------------------------------------------------------------
// grad_dac_serialiser
// Takes words from the gradient BRAM sequencer and shifts each one MSB-first
// onto a shared SPI bus (mode 0) to up to N_CH DACs. A frame runs
// IDLE -> SHIFT (FRAME_BITS SCLK periods) -> HOLD (one half period, CS still
// low) -> GAP (one half period, CS high) -> IDLE. Words offered while a frame
// is in flight are discarded and reported with a one-cycle data_lost pulse.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   data_i         in   word to transmit
//   valid_i        in   per-DAC request mask; nonzero offers a word
//   spi_clk_div_i  in   SCLK half-period minus one, latched at frame accept
//   sclk_o         out  SPI clock, idle low
//   mosi_o         out  SPI data, MSB first, changes on SCLK falling edges
//   cs_n_o         out  active-low chip selects, one per DAC
//   busy_o         out  frame in progress (to sequencer serial_busy_i)
//   data_lost_o    out  one-cycle pulse when a word is dropped
// -----------------------------------------------------------------------------
module grad_dac_serialiser
  import grad_ser_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEFAULT,
  parameter int N_CH       = N_CH_DEFAULT,
  parameter int DIV_WIDTH  = DIV_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FRAME_BITS-1:0] data_i,
  input  logic [N_CH-1:0]       valid_i,
  input  logic [DIV_WIDTH-1:0]  spi_clk_div_i,
  output logic                  sclk_o,
  output logic                  mosi_o,
  output logic [N_CH-1:0]       cs_n_o,
  output logic                  busy_o,
  output logic                  data_lost_o
);

  localparam int BCW = bit_cnt_width(FRAME_BITS);
  localparam logic [BCW-1:0]        BIT_CNT_ZERO = {BCW{1'b0}};
  localparam logic [BCW-1:0]        BIT_CNT_ONE  = {{(BCW-1){1'b0}}, 1'b1};
  localparam logic [BCW-1:0]        BIT_CNT_LAST = BCW'(FRAME_BITS);
  localparam logic [N_CH-1:0]       CS_N_IDLE    = {N_CH{CS_N_RESET[0]}};
  localparam logic [N_CH-1:0]       MASK_NONE    = {N_CH{1'b0}};
  localparam logic [FRAME_BITS-1:0] SHIFT_ZERO   = {FRAME_BITS{1'b0}};

  ser_state_e            state;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [BCW-1:0]        bit_cnt;
  logic                  word_offered;
  logic                  accept;
  logic                  drop;
  logic                  tick_en;
  logic                  tick;

  // Offer decode: a word is accepted only in IDLE; anywhere else it is lost.
  always_comb begin
    word_offered = 1'b0;
    accept       = 1'b0;
    drop         = 1'b0;
    tick_en      = 1'b0;
    word_offered = (valid_i != MASK_NONE);
    if (state == ST_IDLE) begin
      accept  = word_offered;
      drop    = 1'b0;
      tick_en = 1'b0;
    end else begin
      accept  = 1'b0;
      drop    = word_offered;
      tick_en = 1'b1;
    end
  end

  grad_sclk_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_sclk_tick (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .div  (spi_clk_div_i),
    .en   (tick_en),
    .tick (tick)
  );

  // MOSI is the shift register MSB, so it only moves when the register
  // shifts (on SCLK falling edges) and is zero whenever the register is.
  assign mosi_o = shift_reg[FRAME_BITS-1];

  // Frame sequencer: every state transition and SCLK edge happens on a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift_reg <= SHIFT_ZERO;
      bit_cnt   <= BIT_CNT_ZERO;
      sclk_o    <= 1'b0;
      cs_n_o    <= CS_N_IDLE;
      busy_o    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shift_reg <= data_i;
            bit_cnt   <= BIT_CNT_ZERO;
            sclk_o    <= 1'b0;
            cs_n_o    <= ~valid_i;
            busy_o    <= 1'b1;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (!sclk_o) begin
              // Rising edge: DAC samples the bit currently on MOSI.
              sclk_o  <= 1'b1;
              bit_cnt <= bit_cnt + BIT_CNT_ONE;
            end else begin
              // Falling edge: present the next bit, or finish after the last.
              sclk_o <= 1'b0;
              if (bit_cnt == BIT_CNT_LAST) begin
                state <= ST_HOLD;
              end else begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
              end
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            cs_n_o    <= CS_N_IDLE;
            shift_reg <= SHIFT_ZERO;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tick) begin
            busy_o  <= 1'b0;
            bit_cnt <= BIT_CNT_ZERO;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          shift_reg <= SHIFT_ZERO;
          bit_cnt   <= BIT_CNT_ZERO;
          sclk_o    <= 1'b0;
          cs_n_o    <= CS_N_IDLE;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

  // Dropped-word flag: registered, so it pulses the cycle after the offer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_lost_o <= 1'b0;
    end else begin
      data_lost_o <= drop;
    end
  end

endmodule

// File: doc/grad_dac_serialiser.md
Name: grad_dac_serialiser

Overview:
Transmit-side partner of the gradient BRAM sequencer. It consumes each 32-bit output word (data plus 4-bit channel-valid mask) and shifts it MSB-first onto a shared SPI bus to up to four gradient DACs, one active-low chip select per DAC. It drives the sequencer's serial-busy and data-lost inputs, so the sequencer can detect skipped or overrun words.

Parameters:
FRAME_BITS, 32, bits per SPI frame
N_CH, 4, number of DAC chip selects / valid-mask width
DIV_WIDTH, 6, width of SPI clock divisor input

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
data_i  in  FRAME_BITS  word to transmit
valid_i  in  N_CH  per-DAC transmit request; nonzero = new word this cycle
spi_clk_div_i  in  DIV_WIDTH  SCLK half-period minus one, in clk cycles
sclk_o  out  1  SPI clock, idle low
mosi_o  out  1  SPI data, MSB first
cs_n_o  out  N_CH  active-low chip selects
busy_o  out  1  frame in progress; to sequencer serial_busy_i
data_lost_o  out  1  one-cycle pulse on dropped word; to sequencer data_lost_i

Behaviour:
- Reset (async, any state): sclk_o=0, mosi_o=0, cs_n_o=all 1, busy_o=0, data_lost_o=0, state=IDLE, shift register and counters=0. Release mid-frame resumes in IDLE. No partial frame completes.
- H = spi_clk_div_i+1 clk cycles, 1..64. The divisor is latched at frame accept; changes mid-frame have no effect until the next frame.
- SPI mode 0: MOSI stable while SCLK low, DAC samples on SCLK rising edge, MOSI updates on SCLK falling edge.
- States: IDLE -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE, with valid_i != 0 at edge T0:
  - Latch data_i, valid_i and divisor.
  - From T0+1: cs_n_o = ~latched mask, mosi_o = bit 31, sclk_o=0, busy_o=1.
  - Enter SHIFT.
- SHIFT, 64H cycles:
  - Each bit is H cycles SCLK low, then H cycles SCLK high.
  - First rising edge at T0+1+H.
  - On each falling edge, MOSI advances to the next bit.
  - After the 32nd high phase, SCLK returns low and the block enters HOLD.
- HOLD, H cycles: cs_n_o stays asserted and SCLK stays low. Gives CS hold time.
- GAP, H cycles:
  - cs_n_o all 1, mosi_o=0, busy_o still 1.
  - Then IDLE, with busy_o=0 from T0+1+66H.
- Frame occupancy: busy high for exactly 66H cycles. Minimum word interval is 66H+1 cycles.
- Drop rule: valid_i != 0 in any state other than IDLE:
  - The word is ignored.
  - data_lost_o pulses high for one cycle on the following edge.
  - The current frame is unaffected.
  - Applies in every cycle valid_i is nonzero, including the final GAP cycle (no look-ahead acceptance).
- valid_i == 0 in IDLE: nothing happens. Mask bits select which cs_n_o go low; all four selected = broadcast.
- Counters:
  - Half-period counter is DIV_WIDTH+1 bits wide, sized for H=64.
  - Bit counter is 6 bits; terminal count is 32 rising edges.
  - No wrap-around beyond terminal counts.

Decomposition:
- Package grad_ser_pkg:
  - State enum (IDLE, SHIFT, HOLD, GAP).
  - FRAME_BITS/N_CH/DIV_WIDTH defaults.
  - Reset-value constants for cs_n (all ones).
- Sub-module grad_sclk_tick:
  - Loadable half-period counter.
  - Emits a one-cycle tick every H cycles while enabled.
  - Cleared on rst and on frame accept.
- Top level holds the FSM, shift register, bit counter and drop detection.

Test Plan:
- div=1 (H=2), data 0xABCD0123, valid 4'b1111 at T0 -> cs_n_o=0000 at T0+1, first SCLK rise at T0+3, 32 rising edges sampling 0xABCD0123, cs_n_o=1111 at T0+131, busy_o low at T0+133, data_lost_o never high.
- div=0 (H=1), valid 4'b0101, data 0x80000001 -> only cs_n_o[0],[2] low. SCLK = clk/2. MOSI 1 at first rise, 0 for rises 2..31, 1 at rise 32. busy high 66 cycles.
- div=1, second word (0x12345678) at T0+50 -> data_lost_o single pulse at T0+51, first frame still shifts 0xABCD0123 intact. Word at T0+133 (IDLE) accepted normally.
- div=1, spi_clk_div_i changed to 5 at T0+20 -> current frame keeps H=2 (busy low at T0+133). Next frame uses H=6 (busy 396 cycles).
- Assert rst at T0+40 for 1 cycle -> immediately sclk_o=0, mosi_o=0, cs_n_o=1111, busy_o=0. Word offered 2 cycles after release starts a clean full frame.
- Back-to-back words at exact minimum interval (66H+1) with H=2 over 8 frames -> zero data_lost pulses, all 8 frames bit-exact.
